uart_mmio_ctrl: RTL



---
 rtl/uart_mmio_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_mmio_ctrl.sv
// M-stage memory-mapped I/O controller: TX byte buffer, RX FIFO and cycle counter
// behind the 0x8xxxxxxx address space, with combinational read-back to write-back.
module uart_mmio_ctrl #(
    parameter int RX_DEPTH = 8,
    parameter int RX_AW    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] addr,
    input  logic [5:0]  opcode,
    input  logic [7:0]  wdata,
    output logic [7:0]  uart_din,
    output logic        uart_din_valid,
    input  logic        uart_din_ready,
    input  logic [7:0]  uart_dout,
    input  logic        uart_dout_valid,
    output logic        uart_dout_ready,
    output logic        io_sel,
    output logic [31:0] io_rdata
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [5:0] OFF_TX_STAT = 6'h00;
    localparam logic [5:0] OFF_RX_STAT = 6'h04;
    localparam logic [5:0] OFF_TX_DATA = 6'h08;
    localparam logic [5:0] OFF_RX_DATA = 6'h0C;
    localparam logic [5:0] OFF_CYCLE   = 6'h10;

    localparam logic [RX_AW:0]   RX_FULL_COUNT = (RX_AW+1)'(RX_DEPTH);
    localparam logic [RX_AW:0]   COUNT_ONE     = (RX_AW+1)'(1);
    localparam logic [RX_AW-1:0] PTR_ONE       = RX_AW'(1);

    logic            isLoad;
    logic            isStore;
    logic [5:0]      offset;
    logic            txFullReg;
    logic [7:0]      txBufReg;
    logic [RX_AW-1:0] rdPtrReg;
    logic [RX_AW-1:0] wrPtrReg;
    logic [RX_AW:0]  rxCountReg;
    logic [7:0]      rxMem [RX_DEPTH];
    logic [31:0]     cycleCountReg;
    logic            rxEmpty;
    logic            rxFull;
    logic [7:0]      rxHead;
    logic [7:0]      rxCount8;
    logic            txCapture;
    logic            txDrain;
    logic            rxPush;
    logic            rxPop;
    logic            cycleClear;

    assign isLoad  = (opcode == OP_LB) || (opcode == OP_LW) || (opcode == OP_LBU);
    assign isStore = (opcode == OP_SB) || (opcode == OP_SW);
    assign offset  = addr[5:0];
    assign io_sel  = (addr[31:28] == 4'h8) && (isLoad || isStore);

    assign rxEmpty  = (rxCountReg == '0);
    assign rxFull   = (rxCountReg == RX_FULL_COUNT);
    assign rxHead   = rxMem[rdPtrReg];
    assign rxCount8 = 8'(rxCountReg);

    assign uart_din        = txBufReg;
    assign uart_din_valid  = txFullReg;
    assign uart_dout_ready = ~rxFull & ~reset;

    // A store while the buffer is full is dropped even if it drains this cycle.
    assign txDrain    = txFullReg && uart_din_ready;
    assign txCapture  = io_sel && isStore && (offset == OFF_TX_DATA) && !stall && !txFullReg;
    assign rxPush     = uart_dout_valid && uart_dout_ready;
    assign rxPop      = io_sel && isLoad && (offset == OFF_RX_DATA) && !stall && !rxEmpty;
    assign cycleClear = io_sel && isStore && (offset == OFF_CYCLE) && !stall;

    always_comb begin
        io_rdata = '0;
        if (io_sel && isLoad) begin
            case (offset)
                OFF_TX_STAT: io_rdata = {31'b0, ~txFullReg};
                OFF_RX_STAT: io_rdata = {16'b0, rxCount8, 7'b0, ~rxEmpty};
                OFF_RX_DATA: begin
                    if (!rxEmpty) begin
                        if (opcode == OP_LB) io_rdata = {{24{rxHead[7]}}, rxHead};
                        else                 io_rdata = {24'b0, rxHead};
                    end
                end
                OFF_CYCLE:   io_rdata = cycleCountReg;
                default:     io_rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            txFullReg <= 1'b0;
            txBufReg  <= '0;
        end else if (txCapture) begin
            txFullReg <= 1'b1;
            txBufReg  <= wdata;
        end else if (txDrain) begin
            txFullReg <= 1'b0;
        end
    end

    // Storage carries no reset so it can map to distributed RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (rxPush) rxMem[wrPtrReg] <= uart_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtrReg   <= '0;
            wrPtrReg   <= '0;
            rxCountReg <= '0;
        end else begin
            if (rxPush) wrPtrReg <= wrPtrReg + PTR_ONE;
            if (rxPop)  rdPtrReg <= rdPtrReg + PTR_ONE;
            if (rxPush && !rxPop)      rxCountReg <= rxCountReg + COUNT_ONE;
            else if (rxPop && !rxPush) rxCountReg <= rxCountReg - COUNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || cycleClear) cycleCountReg <= '0;
        else                     cycleCountReg <= cycleCountReg + 32'd1;
    end
endmodule
